battleship_game: RTL and testbench
==================================

# battleship_game

Game-state engine for the 5×5 battleship screen. It turns debounced push-button levels into cursor moves, ship placement and shots, with a per-turn countdown and win/lose detection. It owns the three 5×5 matrices (`matriz_barcos`, `matriz_golpes`, `matriz_disparos`) that the VGA video generator consumes directly, so it sits immediately upstream of the display path.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; sets the 1 s prescaler.
- `TURN_SECONDS`, 15: turn countdown reload value, range 1..15.
- `NUM_SHIPS`, 5: ship cells the player places, range 1..25.
- `MAX_SHOTS`, 15: shots available in the attack phase, range 1..25.
- `clk`  in  1  system clock. One clock; all state on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  level; begins or restarts a game.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_fire`  in  1 each  debounced, synchronized levels.
- `enemy_barcos`  in  [4:0][4:0]  enemy ship layout, indexed [row][col]; sampled once.
- `matriz_barcos`  out  [4:0][4:0]  player-placed ships.
- `matriz_disparos`  out  [4:0][4:0]  player shots on the enemy grid.
- `matriz_golpes`  out  [4:0][4:0]  player shots that hit an enemy ship; always a subset of `matriz_disparos`.
- `cursor_row`, `cursor_col`  out  3 each  cursor position, 0..4.
- `seconds_left`  out  4  turn countdown.
- `shots_left`  out  5  remaining shots.
- `state`  out  3  encoded `game_state_t`.
- `win`, `lose`  out  1 each  result flags, held until restart.

## Operation
- **Input conditioning**
  - Every button and `start` goes through a rising-edge detector (previous-level register).
  - At most one action per cycle, priority: fire > up > down > left > right. Simultaneous lower-priority edges are dropped, not queued.
- **Cursor**
  - up/down change the row by ∓1; left/right change the column by ∓1.
  - The cursor wraps (0↔4) and moves in PLACE and ATTACK only.
- **IDLE**
  - Outputs hold their values.
  - A `start` edge clears all matrices, cursor, counters and flags, then enters PLACE.
- **PLACE**
  - Fire on an empty cell sets `matriz_barcos[r][c]` and increments the placed count.
  - Fire on an occupied cell is ignored.
  - When the placed count reaches `NUM_SHIPS`:
    - capture `enemy_barcos`;
    - compute its popcount as the enemy target;
    - reload the timer and `shots_left = MAX_SHOTS`;
    - enter ATTACK.
  - If the enemy popcount is 0, enter WIN instead.
- **ATTACK**
  - Fire on an unshot cell:
    - set `disparos[r][c]`;
    - set `golpes[r][c]` if the captured enemy bit is 1;
    - decrement `shots_left`;
    - reload the timer.
  - Fire on an already-shot cell is ignored: no shot consumed, no timer reload.
  - Timeout auto-shot: the first unshot cell in row-major order (row 0 col 0 first). It is processed exactly like a manual shot.
- **End of game**
  - After a shot is processed:
    - hit count equal to the enemy target → WIN (`win=1`);
    - otherwise `shots_left==0` → LOSE (`lose=1`).
  - WIN and LOSE freeze the matrices. A `start` edge behaves as it does in IDLE.
- **`start` in PLACE/ATTACK** is ignored.

## Timing
- **Reset values**
  - All matrices 0.
  - Cursor (0,0).
  - `state` = IDLE.
  - `seconds_left` = `TURN_SECONDS`.
  - `shots_left` = `MAX_SHOTS`.
  - `win` = `lose` = 0.
  - Prescaler, edge registers and counters 0.
  - Reset mid-game aborts immediately; there is no partial-clear state.
- **Button latency**
  - A level first sampled high at edge N is detected at N.
  - Matrix, cursor and counter updates are visible after edge N+1.
  - A level held high produces one action.
- **Prescaler**
  - Counts 0..`CLK_HZ`−1 in ATTACK only, reset on every reload.
  - One tick per wrap; each tick decrements `seconds_left`.
- **Timeout**
  - A tick that finds `seconds_left==0` triggers the auto-shot on that cycle and reloads.
  - If a manual fire and a timeout occur in the same cycle, the manual shot wins and only one shot is taken.
- **Win/lose**
  - Flags and the state change become visible on the same edge as the final shot's matrix update.
- **Widths**
  - Hit and target counters are 5 bits.
  - The popcount is combinational over 25 bits and registered at the PLACE→ATTACK transition.

## Structure
- **`battleship_pkg`**
  - `GRID = 5`.
  - `typedef logic [GRID-1:0][GRID-1:0] grid_t`.
  - `game_state_t` enum: IDLE, PLACE, ATTACK, WIN, LOSE.
  - Helper function `first_free(grid_t)` returning {found, row, col}.
- **Sub-module `turn_timer`** (`CLK_HZ`, `TURN_SECONDS`)
  - Inputs: `clk`, `rst`, `run`, `reload`.
  - Outputs: `seconds_left`, `expire`.
- **Top FSM**, cursor and matrices stay in `battleship_game`.

## Test plan
All scenarios use `CLK_HZ=4`, `TURN_SECONDS=2`, `NUM_SHIPS=2`, `MAX_SHOTS=3`.
- **Reset:** assert `rst` asynchronously mid-ATTACK → all outputs return to their reset values with no clock edge; `state` = IDLE.
- **Wrap and priority:** left from (0,0) → (0,4); up → (4,4). up and right edges in the same cycle → (3,4) only.
- **Placement:** fire at (0,0), fire at (0,0) again, fire at (1,1) → `matriz_barcos` bits [0][0] and [1][1] set, state = ATTACK, `shots_left` = 3, enemy layout captured.
- **Hit/miss/duplicate:** enemy ships at (2,2) and (3,3).
  - Fire at (2,2) → golpes[2][2]=1, `shots_left`=2.
  - Fire at (2,2) again → no change.
  - Fire at (0,0) → disparos only, `shots_left`=1.
- **Timeout:** idle in ATTACK for (`TURN_SECONDS`+1)×`CLK_HZ` cycles → auto-shot at the first unshot cell in row-major order, timer reloads to 2.
- **End:** hit both enemy cells within 3 shots → `win=1`, state = WIN. Restart and miss 3 times → `lose=1`. A `start` edge afterwards → PLACE with all matrices cleared.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg: shared grid type, game states and grid helper functions
package battleship_pkg;
    localparam int GRID = 5;
    typedef logic [GRID-1:0][GRID-1:0] grid_t;
    typedef enum logic [2:0] {IDLE, PLACE, ATTACK, WIN, LOSE} game_state_t;
    typedef struct packed {
        logic       found;
        logic [2:0] row;
        logic [2:0] col;
    } cell_t;

    // Scanning backwards leaves the lowest row-major free cell as the final hit.
    function automatic cell_t first_free(grid_t g);
        cell_t f;
        f = '0;
        for (int r = GRID - 1; r >= 0; r--)
            for (int c = GRID - 1; c >= 0; c--)
                if (!g[r][c]) f = '{1'b1, 3'(r), 3'(c)};
        return f;
    endfunction

    function automatic logic [4:0] popcount(grid_t g);
        logic [4:0] n;
        n = '0;
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                n = n + 5'(g[r][c]);
        return n;
    endfunction
endpackage

// File: rtl/battleship_if.sv
// battleship_if: button levels and enemy layout in, game matrices and status out
interface battleship_if;
    import battleship_pkg::*;
    logic        start;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    grid_t       enemy_barcos;
    grid_t       matriz_barcos;
    grid_t       matriz_disparos;
    grid_t       matriz_golpes;
    logic [2:0]  cursor_row;
    logic [2:0]  cursor_col;
    logic [3:0]  seconds_left;
    logic [4:0]  shots_left;
    game_state_t state;
    logic        win;
    logic        lose;

    modport master (
        output start, btn_up, btn_down, btn_left, btn_right, btn_fire, enemy_barcos,
        input  matriz_barcos, matriz_disparos, matriz_golpes, cursor_row, cursor_col,
               seconds_left, shots_left, state, win, lose
    );
    modport slave (
        input  start, btn_up, btn_down, btn_left, btn_right, btn_fire, enemy_barcos,
        output matriz_barcos, matriz_disparos, matriz_golpes, cursor_row, cursor_col,
               seconds_left, shots_left, state, win, lose
    );
endinterface

// File: rtl/battleship_game_turn_timer.sv
// turn_timer: one-second prescaler and per-turn countdown with expiry pulse
module turn_timer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       reload,
    output logic [3:0] seconds_left,
    output logic       expire
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_q, sec_d;
    logic          tick;

    // Tick on prescaler wrap; an expiry reloads the countdown on its own cycle
    always_comb begin
        tick    = run && presc_q == PW'(CLK_HZ - 1);
        expire  = tick && sec_q == 4'd0;
        presc_d = (reload || tick) ? '0 : run ? presc_q + 1'b1 : presc_q;
        sec_d   = (reload || expire) ? 4'(TURN_SECONDS) : tick ? sec_q - 4'd1 : sec_q;
    end

    // Timer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= 4'(TURN_SECONDS);
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign seconds_left = sec_q;
endmodule

// File: rtl/battleship_game.sv
// battleship_game: cursor, placement, shooting and win/lose engine for the 5x5 board
module battleship_game #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 15,
    parameter int NUM_SHIPS    = 5,
    parameter int MAX_SHOTS    = 15
) (
    input logic         clk,
    input logic         rst,
    battleship_if.slave gif
);
    import battleship_pkg::*;

    game_state_t state_q, state_d;
    grid_t       barcos_q, barcos_d, disparos_q, disparos_d, golpes_q, golpes_d, enemy_q, enemy_d;
    logic [4:0]  target_q, target_d, hits_q, hits_d, placed_q, placed_d, shots_q, shots_d;
    logic [2:0]  row_q, row_d, col_q, col_d;
    logic        win_q, win_d, lose_q, lose_d;
    logic [5:0]  lvl, prev_q, edge_q;
    logic        start_e, fire_e, up_e, down_e, left_e, right_e;
    logic        reload, expire, run, manual, shoot, hit;
    logic [2:0]  sr, sc;
    logic [4:0]  pop, hits_n;
    logic [3:0]  secs;
    cell_t       ff;

    assign lvl = {gif.start, gif.btn_fire, gif.btn_up, gif.btn_down, gif.btn_left, gif.btn_right};
    assign run = state_q == ATTACK;

    turn_timer #(.CLK_HZ(CLK_HZ), .TURN_SECONDS(TURN_SECONDS)) u_timer (
        .clk(clk), .rst(rst), .run(run), .reload(reload), .seconds_left(secs), .expire(expire)
    );

    // State register plus registered button edges (detected at N, acted on at N+1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            barcos_q <= '0; disparos_q <= '0; golpes_q <= '0; enemy_q <= '0;
            target_q <= '0; hits_q <= '0; placed_q <= '0; shots_q <= 5'(MAX_SHOTS);
            row_q <= '0; col_q <= '0; win_q <= 1'b0; lose_q <= 1'b0;
            prev_q <= '0; edge_q <= '0;
        end else begin
            state_q <= state_d;
            barcos_q <= barcos_d; disparos_q <= disparos_d; golpes_q <= golpes_d; enemy_q <= enemy_d;
            target_q <= target_d; hits_q <= hits_d; placed_q <= placed_d; shots_q <= shots_d;
            row_q <= row_d; col_q <= col_d; win_q <= win_d; lose_q <= lose_d;
            prev_q <= lvl; edge_q <= lvl & ~prev_q;
        end
    end

    // Next state: one prioritised action per cycle, a manual shot beats a timeout shot
    always_comb begin
        state_d = state_q;
        barcos_d = barcos_q; disparos_d = disparos_q; golpes_d = golpes_q; enemy_d = enemy_q;
        target_d = target_q; hits_d = hits_q; placed_d = placed_q; shots_d = shots_q;
        row_d = row_q; col_d = col_q; win_d = win_q; lose_d = lose_q;
        reload = 1'b0;
        start_e = edge_q[5];
        fire_e = edge_q[4];
        up_e = edge_q[3] && !edge_q[4];
        down_e = edge_q[2] && !(|edge_q[4:3]);
        left_e = edge_q[1] && !(|edge_q[4:2]);
        right_e = edge_q[0] && !(|edge_q[4:1]);
        pop = popcount(gif.enemy_barcos);
        ff = first_free(disparos_q);
        manual = state_q == ATTACK && fire_e && !disparos_q[row_q][col_q];
        shoot = manual || (state_q == ATTACK && expire && ff.found);
        sr = manual ? row_q : ff.row;
        sc = manual ? col_q : ff.col;
        hit = enemy_q[sr][sc];
        hits_n = hits_q + 5'(hit);
        if (start_e && (state_q == IDLE || state_q == WIN || state_q == LOSE)) begin
            state_d = PLACE;
            barcos_d = '0; disparos_d = '0; golpes_d = '0; enemy_d = '0;
            target_d = '0; hits_d = '0; placed_d = '0; shots_d = 5'(MAX_SHOTS);
            row_d = '0; col_d = '0; win_d = 1'b0; lose_d = 1'b0;
            reload = 1'b1;
        end else if (state_q == PLACE || state_q == ATTACK) begin
            row_d = up_e ? (row_q == 3'd0 ? 3'(GRID - 1) : row_q - 3'd1)
                  : down_e ? (row_q == 3'(GRID - 1) ? 3'd0 : row_q + 3'd1) : row_q;
            col_d = left_e ? (col_q == 3'd0 ? 3'(GRID - 1) : col_q - 3'd1)
                  : right_e ? (col_q == 3'(GRID - 1) ? 3'd0 : col_q + 3'd1) : col_q;
            if (state_q == PLACE && fire_e && !barcos_q[row_q][col_q]) begin
                barcos_d[row_q][col_q] = 1'b1;
                placed_d = placed_q + 5'd1;
                if (placed_d == 5'(NUM_SHIPS)) begin
                    enemy_d = gif.enemy_barcos;
                    target_d = pop;
                    shots_d = 5'(MAX_SHOTS);
                    reload = 1'b1;
                    state_d = pop == 5'd0 ? WIN : ATTACK;
                    win_d = pop == 5'd0;
                end
            end
            if (shoot) begin
                disparos_d[sr][sc] = 1'b1;
                golpes_d[sr][sc] = hit;
                hits_d = hits_n;
                shots_d = shots_q - 5'd1;
                reload = 1'b1;
                if (hits_n == target_q) begin
                    state_d = WIN;
                    win_d = 1'b1;
                end else if (shots_d == 5'd0) begin
                    state_d = LOSE;
                    lose_d = 1'b1;
                end
            end
        end
    end

    // Drive the registered game view onto the bus
    always_comb begin
        gif.matriz_barcos = barcos_q;
        gif.matriz_disparos = disparos_q;
        gif.matriz_golpes = golpes_q;
        gif.cursor_row = row_q;
        gif.cursor_col = col_q;
        gif.seconds_left = secs;
        gif.shots_left = shots_q;
        gif.state = state_q;
        gif.win = win_q;
        gif.lose = lose_q;
    end
endmodule

// File: tb/tb_battleship_game.sv
// tb_battleship_game: directed scenarios for placement, shots, timeout and game end
module tb_battleship_game;
    import battleship_pkg::*;

    localparam logic [5:0] ST = 6'b100000, FI = 6'b010000, UP = 6'b001000;
    localparam logic [5:0] DN = 6'b000100, LF = 6'b000010, RT = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;
    grid_t ships;

    battleship_if bif();

    battleship_game #(.CLK_HZ(4), .TURN_SECONDS(2), .NUM_SHIPS(2), .MAX_SHOTS(3)) dut (
        .clk(clk), .rst(rst), .gif(bif.slave)
    );

    always #5 clk = ~clk;

    task automatic press(input logic [5:0] m);
        {bif.start, bif.btn_fire, bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right} = m;
        @(negedge clk);
        {bif.start, bif.btn_fire, bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right} = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vecs++; if (bif.state !== IDLE) begin errs++; $display("FAIL reset_state got %0d want %0d", bif.state, IDLE); end
        vecs++; if (bif.shots_left !== 5'd3) begin errs++; $display("FAIL reset_shots got %0d want 3", bif.shots_left); end
        vecs++; if (bif.seconds_left !== 4'd2) begin errs++; $display("FAIL reset_secs got %0d want 2", bif.seconds_left); end
        vecs++; if ({bif.matriz_barcos, bif.matriz_disparos, bif.matriz_golpes, bif.cursor_row, bif.cursor_col, bif.win, bif.lose} !== '0)
            begin errs++; $display("FAIL reset_clear got nonzero want all zero"); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap_priority;
        press(ST);
        vecs++; if (bif.state !== PLACE) begin errs++; $display("FAIL start_place got %0d want %0d", bif.state, PLACE); end
        press(LF);
        vecs++; if ({bif.cursor_row, bif.cursor_col} !== {3'd0, 3'd4}) begin errs++; $display("FAIL wrap_left got (%0d,%0d) want (0,4)", bif.cursor_row, bif.cursor_col); end
        press(UP);
        vecs++; if ({bif.cursor_row, bif.cursor_col} !== {3'd4, 3'd4}) begin errs++; $display("FAIL wrap_up got (%0d,%0d) want (4,4)", bif.cursor_row, bif.cursor_col); end
        press(UP | RT);
        vecs++; if ({bif.cursor_row, bif.cursor_col} !== {3'd3, 3'd4}) begin errs++; $display("FAIL priority got (%0d,%0d) want (3,4)", bif.cursor_row, bif.cursor_col); end
        press(RT); press(UP); press(UP); press(UP);
        vecs++; if ({bif.cursor_row, bif.cursor_col} !== {3'd0, 3'd0}) begin errs++; $display("FAIL home got (%0d,%0d) want (0,0)", bif.cursor_row, bif.cursor_col); end
    endtask

    task automatic test_placement;
        bif.enemy_barcos = ships;
        press(FI);
        press(FI);
        vecs++; if (bif.matriz_barcos !== 25'h1 || bif.state !== PLACE) begin errs++; $display("FAIL place_dup got barcos=%h state=%0d want 1 state 1", bif.matriz_barcos, bif.state); end
        bif.btn_down = 1'b1;
        repeat (4) @(negedge clk);
        bif.btn_down = 1'b0;
        @(negedge clk);
        vecs++; if (bif.cursor_row !== 3'd1) begin errs++; $display("FAIL hold_one got row %0d want 1", bif.cursor_row); end
        press(RT);
        press(FI);
        vecs++; if (bif.matriz_barcos !== 25'h41) begin errs++; $display("FAIL place_barcos got %h want 0000041", bif.matriz_barcos); end
        vecs++; if (bif.state !== ATTACK || bif.shots_left !== 5'd3 || bif.seconds_left !== 4'd2)
            begin errs++; $display("FAIL place_attack got state=%0d shots=%0d secs=%0d want 2/3/2", bif.state, bif.shots_left, bif.seconds_left); end
    endtask

    task automatic test_hit_miss_timeout;
        press(DN); press(RT); press(FI);
        vecs++; if (bif.matriz_golpes !== 25'h1000 || bif.matriz_disparos !== 25'h1000) begin errs++; $display("FAIL hit got golpes=%h disparos=%h want 1000/1000", bif.matriz_golpes, bif.matriz_disparos); end
        vecs++; if (bif.shots_left !== 5'd2 || bif.seconds_left !== 4'd2) begin errs++; $display("FAIL hit_counts got shots=%0d secs=%0d want 2/2", bif.shots_left, bif.seconds_left); end
        press(UP); press(UP); press(LF); press(LF); press(FI);
        vecs++; if (bif.matriz_disparos !== 25'h1001 || bif.matriz_golpes !== 25'h1000 || bif.shots_left !== 5'd1)
            begin errs++; $display("FAIL miss got disparos=%h golpes=%h shots=%0d want 1001/1000/1", bif.matriz_disparos, bif.matriz_golpes, bif.shots_left); end
        press(FI);
        vecs++; if (bif.matriz_disparos !== 25'h1001 || bif.shots_left !== 5'd1) begin errs++; $display("FAIL dup got disparos=%h shots=%0d want 1001/1", bif.matriz_disparos, bif.shots_left); end
        repeat (9) @(negedge clk);
        vecs++; if (bif.seconds_left !== 4'd0 || bif.matriz_disparos !== 25'h1001) begin errs++; $display("FAIL pre_timeout got secs=%0d disparos=%h want 0/1001", bif.seconds_left, bif.matriz_disparos); end
        @(negedge clk);
        vecs++; if (bif.matriz_disparos !== 25'h1003 || bif.seconds_left !== 4'd2 || bif.shots_left !== 5'd0)
            begin errs++; $display("FAIL timeout got disparos=%h secs=%0d shots=%0d want 1003/2/0", bif.matriz_disparos, bif.seconds_left, bif.shots_left); end
        vecs++; if (bif.state !== LOSE || bif.lose !== 1'b1) begin errs++; $display("FAIL timeout_lose got state=%0d lose=%b want 4/1", bif.state, bif.lose); end
    endtask

    task automatic test_win;
        press(ST);
        vecs++; if (bif.state !== PLACE || bif.matriz_disparos !== '0 || bif.lose !== 1'b0) begin errs++; $display("FAIL restart got state=%0d disparos=%h lose=%b", bif.state, bif.matriz_disparos, bif.lose); end
        press(FI); press(RT); press(FI);
        press(DN); press(DN); press(RT); press(FI);
        press(DN); press(RT); press(FI);
        vecs++; if (bif.matriz_golpes !== 25'h41000 || bif.matriz_disparos !== 25'h41000) begin errs++; $display("FAIL win_grid got golpes=%h disparos=%h want 41000", bif.matriz_golpes, bif.matriz_disparos); end
        vecs++; if (bif.state !== WIN || bif.win !== 1'b1 || bif.shots_left !== 5'd1) begin errs++; $display("FAIL win got state=%0d win=%b shots=%0d want 3/1/1", bif.state, bif.win, bif.shots_left); end
    endtask

    task automatic test_lose;
        press(ST);
        press(FI); press(RT); press(FI);
        press(FI); press(RT); press(FI); press(RT); press(FI);
        vecs++; if (bif.matriz_disparos !== 25'hE || bif.matriz_golpes !== '0) begin errs++; $display("FAIL lose_grid got disparos=%h golpes=%h want 000000e/0", bif.matriz_disparos, bif.matriz_golpes); end
        vecs++; if (bif.state !== LOSE || bif.lose !== 1'b1 || bif.win !== 1'b0) begin errs++; $display("FAIL lose got state=%0d lose=%b win=%b want 4/1/0", bif.state, bif.lose, bif.win); end
        press(ST);
        vecs++; if (bif.state !== PLACE || {bif.matriz_barcos, bif.matriz_disparos, bif.matriz_golpes} !== '0 || bif.lose !== 1'b0 || bif.shots_left !== 5'd3)
            begin errs++; $display("FAIL restart_clear got state=%0d barcos=%h lose=%b shots=%0d", bif.state, bif.matriz_barcos, bif.lose, bif.shots_left); end
    endtask

    task automatic test_back_to_back;
        press(ST);
        vecs++; if (bif.state !== PLACE) begin errs++; $display("FAIL start_ignored got %0d want 1", bif.state); end
        bif.enemy_barcos = '0;
        press(FI); press(RT); press(FI);
        vecs++; if (bif.state !== WIN || bif.win !== 1'b1) begin errs++; $display("FAIL empty_enemy got state=%0d win=%b want 3/1", bif.state, bif.win); end
    endtask

    task automatic test_async_reset;
        bif.enemy_barcos = ships;
        press(ST); press(FI); press(RT); press(FI); press(FI);
        vecs++; if (bif.state !== ATTACK || bif.shots_left !== 5'd2) begin errs++; $display("FAIL pre_reset got state=%0d shots=%0d want 2/2", bif.state, bif.shots_left); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (bif.state !== IDLE || bif.shots_left !== 5'd3 || bif.seconds_left !== 4'd2) begin errs++; $display("FAIL async_reset got state=%0d shots=%0d secs=%0d want 0/3/2", bif.state, bif.shots_left, bif.seconds_left); end
        vecs++; if ({bif.matriz_barcos, bif.matriz_disparos, bif.cursor_col} !== '0) begin errs++; $display("FAIL async_clear got barcos=%h disparos=%h col=%0d want 0", bif.matriz_barcos, bif.matriz_disparos, bif.cursor_col); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        {bif.start, bif.btn_fire, bif.btn_up, bif.btn_down, bif.btn_left, bif.btn_right} = '0;
        ships = '0;
        ships[2][2] = 1'b1;
        ships[3][3] = 1'b1;
        bif.enemy_barcos = '0;
        test_reset;
        test_wrap_priority;
        test_placement;
        test_hit_miss_timeout;
        test_win;
        test_lose;
        test_back_to_back;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
